booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one sequential 8x8 signed radix-4 Booth multiplier unit between NREQ requesters.
- Arbitrates round-robin, latches the winner's operands, and issues a one-cycle start to the multiplier.
- Waits for the unit's done pulse, then returns the 16-bit product to the owning requester under a valid/ready handshake.
- Sits between the client blocks and the multiplier datapath. It is the only driver of the multiplier's operand and start inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request pending.
- req_mp  input  NREQ*W  multipliers; slice i = [i*W +: W].
- req_mc  input  NREQ*W  multiplicands; same slicing.
- req_ready  output  NREQ  one-hot one-cycle accept pulse.
- rsp_valid  output  NREQ  one-hot; product valid for that requester.
- rsp_prod  output  2*W  product, shared by all requesters.
- rsp_ready  input  NREQ  per-requester response accept.
- mul_mp  output  W  operand to the multiplier unit.
- mul_mc  output  W  operand to the multiplier unit.
- mul_start  output  1  one-cycle start pulse.
- mul_done  input  1  one-cycle completion pulse from the unit.
- mul_prod  input  2*W  unit product, valid when mul_done=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - All outputs to 0: req_ready, rsp_valid, rsp_prod, mul_mp, mul_mc, mul_start, busy.
- Reset mid-operation abandons the in-flight product. A mul_done arriving after reset is ignored.
- FSM states: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning upward from rr_ptr, wrapping modulo NREQ.
  - Register owner, and latch req_mp/req_mc of the owner into mul_mp/mul_mc.
  - Pulse req_ready[owner] for exactly one cycle, the cycle of the IDLE->LAUNCH transition (registered output, visible in the first LAUNCH cycle).
  - If no req_valid is set, stay in IDLE.
- LAUNCH: mul_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold mul_mp/mul_mc stable.
  - On mul_done=1, capture mul_prod into rsp_prod and go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_prod is held stable.
  - When rsp_ready[owner]=1: clear rsp_valid, set rr_ptr = (owner+1) mod NREQ, return to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency: accept to mul_start is 1 cycle. mul_done to rsp_valid is 1 cycle. Minimum IDLE-to-IDLE turnaround is 3 cycles plus the multiplier latency.
- mul_done outside WAIT is ignored. A second mul_done in WAIT cannot occur because the state exits on the first.
- A requester may deassert req_valid before it is granted. It is not granted unless req_valid is high at the IDLE grant edge.
- A requester keeping req_valid asserted after its accept is treated as a new request. It becomes eligible again only after every other pending requester has been served.
- The product is the unit's 2*W two's-complement result, passed through unmodified.
- Fairness: no requester waits longer than NREQ-1 other transactions.

Optional Feature:
- Macro: MUL_WATCHDOG_EN.
- With the macro defined:
  - Adds a parameter WDOG_CYC, default 64.
  - Adds an output port mul_timeout (1 bit, reset 0).
  - A counter clears on entry to WAIT. If it reaches WDOG_CYC without mul_done, the FSM goes to RESP with rsp_prod = 0.
  - mul_timeout is sticky until rst.
- Without the macro: no counter, no port, and WAIT lasts indefinitely.

Decomposition:
- Shared package booth_mul_pkg:
  - FSM state encoding (IDLE, LAUNCH, WAIT, RESP).
  - Default W and product-width constant.
  - WDOG_CYC default.
- Sub-module rr_arbiter: combinational one-hot grant from the request vector and rr_ptr, plus a binary grant index. It is instantiated once. The pointer register stays in the parent.

Test Plan:
1. Single request: requester 0 sends mp=7, mc=-3. Response: req_ready[0] pulse, mul_start one cycle later, after mul_done rsp_valid[0]=1 with rsp_prod=16'hFFEB. Hold rsp_ready=0 for 5 cycles and check that the product stays stable.
2. All four requesters valid continuously, with rsp_ready always 1. Grants must run in order 0,1,2,3,0. Each requester receives its own product; e.g. req2 mp=-128, mc=-128 gives 16'h4000.
3. rr_ptr=2 with requests only on 0 and 3. Requester 3 is granted first, then 0 (wrap-around).
4. Assert rst during WAIT, with mul_done arriving 2 cycles later. All outputs read 0, the state is IDLE, and no rsp_valid pulse occurs.
5. Stray mul_done in IDLE and LAUNCH is ignored. rsp_ready from a non-owner in RESP is ignored.
6. With MUL_WATCHDOG_EN and WDOG_CYC=8: mul_done is never sent. After 8 WAIT cycles, rsp_valid=1, rsp_prod=0 and mul_timeout=1, and mul_timeout stays high until rst.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared types and defaults for the Booth multiplier arbiter
//
// Purpose: FSM state encoding and default sizing constants shared by
//          booth_mul_arbiter and rr_arbiter.
// Ports:   none (package).
package booth_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_PROD_W   = 2 * DEF_W;
    localparam int DEF_WDOG_CYC = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selector
//
// Purpose: grants the first set request bit at or above ptr, wrapping
//          modulo N. The pointer register lives in the parent.
// Ports:   req     - request vector
//          ptr     - highest-priority index for this decision
//          gnt     - one-hot grant (zero when no request)
//          gnt_idx - binary index of the granted requester
//          gnt_any - at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[PW-1:0];
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one sequential Booth multiplier
//
// Purpose: arbitrates NREQ requesters onto one multiplier unit, launches it,
//          waits for done and returns the product under valid/ready.
// Ports:   clk, rst (sync, active high)
//          req_valid/req_mp/req_mc/req_ready - request side, W-bit slices
//          rsp_valid/rsp_prod/rsp_ready      - response side, product shared
//          mul_mp/mul_mc/mul_start           - drive the multiplier unit
//          mul_done/mul_prod                 - multiplier completion
//          busy                              - FSM not in IDLE
//          mul_timeout                       - sticky watchdog flag (MUL_WATCHDOG_EN)
// Option:  MUL_WATCHDOG_EN adds WDOG_CYC and mul_timeout.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
`ifdef MUL_WATCHDOG_EN
    ,
    parameter int WDOG_CYC = DEF_WDOG_CYC
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_mp,
    input  logic [NREQ*W-1:0]   req_mc,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_prod,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        mul_mp,
    output logic [W-1:0]        mul_mc,
    output logic                mul_start,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_prod,
`ifdef MUL_WATCHDOG_EN
    output logic                mul_timeout,
`endif
    output logic                busy
);

    localparam int PW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [W-1:0]    mp_q, mp_d, mc_q, mc_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic            start_q, start_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            wdog_expire;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef MUL_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);
    logic [CW-1:0] wdog_q;
    logic          timeout_q;

    // Fires on the WDOG_CYC-th WAIT cycle without a done pulse.
    assign wdog_expire = (state_q == ST_WAIT) && !mul_done &&
                         (wdog_q == CW'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_LAUNCH) begin
                wdog_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mul_timeout = timeout_q;
`else
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            mp_q        <= '0;
            mc_q        <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            prod_q      <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            mp_q        <= mp_d;
            mc_q        <= mc_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            prod_q      <= prod_d;
            start_q     <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_any) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (mul_done || wdog_expire) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready[owner_q]) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: req_ready and mul_start are one-cycle pulses that
    // appear in the cycle after the decision, so their _d defaults to zero.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        mp_d        = mp_q;
        mc_d        = mc_q;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        prod_d      = prod_q;
        start_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    owner_d     = gnt_idx;
                    mp_d        = req_mp[int'(gnt_idx)*W +: W];
                    mc_d        = req_mc[int'(gnt_idx)*W +: W];
                    req_ready_d = gnt;
                end
            end
            ST_LAUNCH: start_d = 1'b1;
            ST_WAIT: begin
                if (mul_done) begin
                    prod_d      = mul_prod;
                    rsp_valid_d = NREQ'(1) << owner_q;
                end else if (wdog_expire) begin
                    prod_d      = '0;
                    rsp_valid_d = NREQ'(1) << owner_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = prod_q;
    assign mul_mp    = mp_q;
    assign mul_mc    = mc_q;
    assign mul_start = start_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - directed self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_mp;
    logic [31:0] req_mc;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_prod;
    logic [3:0]  rsp_ready;
    logic [7:0]  mul_mp;
    logic [7:0]  mul_mc;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_prod;
    logic        busy;
`ifdef MUL_WATCHDOG_EN
    logic        mul_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // multiplier stand-in controls
    bit auto_mul  = 1'b1;
    int lat       = 3;
    int stray_req = 0;
    int stray_seen = 0;
    bit pend = 1'b0;
    int mcnt = 0;
    logic [15:0] prod_l = '0;

    always #5 clk = ~clk;

    booth_mul_arbiter #(
        .NREQ(4),
        .W(8)
`ifdef MUL_WATCHDOG_EN
        ,
        .WDOG_CYC(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mp(req_mp), .req_mc(req_mc),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_ready(rsp_ready),
        .mul_mp(mul_mp), .mul_mc(mul_mc), .mul_start(mul_start),
        .mul_done(mul_done), .mul_prod(mul_prod),
`ifdef MUL_WATCHDOG_EN
        .mul_timeout(mul_timeout),
`endif
        .busy(busy)
    );

    // Behavioural multiplier unit: done pulse lat cycles after a start.
    initial begin
        mul_done = 1'b0;
        mul_prod = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (pend) begin
                if (mcnt == 0) begin
                    mul_done = 1'b1;
                    mul_prod = prod_l;
                    pend     = 1'b0;
                end else begin
                    mcnt--;
                end
            end
            if (auto_mul && mul_start) begin
                pend   = 1'b1;
                mcnt   = lat - 1;
                prod_l = 16'($signed(mul_mp) * $signed(mul_mc));
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                mul_done   = 1'b1;
                mul_prod   = 16'h1234;
            end
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready == 4'b0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) expect_eq({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid == 4'b0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) expect_eq({tag, "_rsp_timeout"}, 0, 1);
    endtask

    task automatic serve(input string tag, input int idx, input logic [15:0] prod);
        wait_ready(tag);
        expect_eq({tag, "_grant"}, 32'(req_ready), 32'(4'b1 << idx));
        tick();
        wait_rsp(tag);
        expect_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(4'b1 << idx));
        expect_eq({tag, "_rsp_prod"}, 32'(rsp_prod), 32'(prod));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_mp    = '0;
        req_mc    = '0;
        rsp_ready = '0;
        tick();
        tick();
        // reset state
        expect_eq("rst_outputs", {busy, mul_start, req_ready, rsp_valid},  0);
        expect_eq("rst_data", {rsp_prod, mul_mp, mul_mc}, 0);
        rst = 1'b0;
        tick();

        // 1: single request 7 * -3 = -21
        req_mp[7:0] = 8'd7;
        req_mc[7:0] = 8'hFD;
        req_valid   = 4'b0001;
        tick();
        expect_eq("t1_req_ready", 32'(req_ready), 1);
        expect_eq("t1_no_start_yet", 32'(mul_start), 0);
        expect_eq("t1_busy", 32'(busy), 1);
        expect_eq("t1_mul_ops", {mul_mp, mul_mc}, 32'h07FD);
        req_valid = 4'b0000;
        tick();
        expect_eq("t1_ready_pulse", 32'(req_ready), 0);
        expect_eq("t1_start", 32'(mul_start), 1);
        tick();
        expect_eq("t1_start_pulse", 32'(mul_start), 0);
        wait_rsp("t1");
        expect_eq("t1_rsp_valid", 32'(rsp_valid), 1);
        expect_eq("t1_rsp_prod", 32'(rsp_prod), 32'hFFEB);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_eq("t1_hold", {rsp_valid, rsp_prod}, 32'h1FFEB);
        end
        rsp_ready = 4'b0001;
        tick();
        expect_eq("t1_rsp_done", {busy, rsp_valid}, 0);
        rsp_ready = 4'b0000;

        // 2: all requesters continuously valid, order 0,1,2,3,0
        do_reset();
        req_mp    = {8'd127, 8'h80, 8'hFF, 8'd3};
        req_mc    = {8'h80,  8'h80, 8'd100, 8'd5};
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        serve("t2_r0", 0, 16'h000F);
        serve("t2_r1", 1, 16'hFF9C);
        serve("t2_r2", 2, 16'h4000);
        serve("t2_r3", 3, 16'hC080);
        serve("t2_r0b", 0, 16'h000F);
        req_valid = 4'b0000;

        // 3: move rr_ptr to 2, then requests on 0 and 3 only -> 3 then 0
        do_reset();
        req_valid = 4'b0010;
        serve("t3_r1", 1, 16'hFF9C);
        req_valid = 4'b1001;
        serve("t3_r3", 3, 16'hC080);
        serve("t3_r0", 0, 16'h000F);
        req_valid = 4'b0000;

        // 4: reset during WAIT, done lands 2 cycles after reset
        do_reset();
        lat       = 4;
        req_valid = 4'b0001;
        tick();
        expect_eq("t4_grant", 32'(req_ready), 1);
        req_valid = 4'b0000;
        tick();
        expect_eq("t4_start", 32'(mul_start), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_eq("t4_rst_outputs", {busy, mul_start, req_ready, rsp_valid}, 0);
        expect_eq("t4_rst_data", {rsp_prod, mul_mp, mul_mc}, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_eq("t4_no_rsp", {busy, rsp_valid}, 0);
        end
        lat = 3;

        // 5: stray done in IDLE and LAUNCH, non-owner rsp_ready in RESP
        rsp_ready = 4'b0000;
        stray_req++;
        tick();
        tick();
        expect_eq("t5_idle_stray", {busy, rsp_valid}, 0);
        req_valid = 4'b0100;
        tick();
        expect_eq("t5_grant", 32'(req_ready), 32'h4);
        req_valid = 4'b0000;
        stray_req++;
        rsp_ready = 4'b1011;
        tick();
        expect_eq("t5_launch_stray", {mul_start, rsp_valid}, 32'h10);
        wait_rsp("t5");
        expect_eq("t5_rsp", {rsp_valid, rsp_prod}, 32'h44000);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_eq("t5_nonowner_ready", {rsp_valid, rsp_prod}, 32'h44000);
        end
        rsp_ready = 4'b1111;
        tick();
        expect_eq("t5_release", {busy, rsp_valid}, 0);

`ifdef MUL_WATCHDOG_EN
        // 6: watchdog with no done pulse
        do_reset();
        rsp_ready = 4'b0000;
        auto_mul  = 1'b0;
        req_valid = 4'b0010;
        tick();
        expect_eq("t6_grant", 32'(req_ready), 32'h2);
        req_valid = 4'b0000;
        tick();
        expect_eq("t6_start", 32'(mul_start), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_eq("t6_waiting", {mul_timeout, rsp_valid}, 0);
        end
        tick();
        expect_eq("t6_timeout_rsp", {mul_timeout, rsp_valid, rsp_prod}, 32'h120000);
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
        tick();
        expect_eq("t6_sticky", {mul_timeout, busy}, 32'h2);
        do_reset();
        expect_eq("t6_cleared", 32'(mul_timeout), 0);
        auto_mul = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
